// File: rtl/calc_serial_tx_fifo_if.sv
// Write-side handshake between a producer and the serial transmitter FIFO.
interface calc_serial_tx_fifo_if #(
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  wr_valid;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_ready;

   modport master (output wr_valid, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/calc_serial_tx_fifo.sv
// Word FIFO feeding a divided-clock serial shifter with selectable bit order.
module calc_serial_tx_fifo #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned DIV_WIDTH   = 32,
   parameter int unsigned DIV_DEFAULT = 2
) (
   input  logic                             clk,
   input  logic                             rst_n,
   calc_serial_tx_fifo_if.slave             wr_if,
   input  logic                             config_div_i,
   input  logic [DIV_WIDTH-1:0]             din_i,
   input  logic                             enable_i,
   input  logic                             msb_first_i,
   output logic                             data_out_o,
   output logic                             clk_tx_o,
   output logic                             tx_active_o,
   output logic                             tx_done_o,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count_o,
   output logic [DIV_WIDTH-1:0]             freq_div_target_o
);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
   localparam int unsigned HLF_W = DIV_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [DIV_WIDTH-1:0]   target_q, target_d, div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
   logic                   msb_q, msb_d;
   logic                   data_out_q, data_out_d, clk_tx_q, clk_tx_d;
   logic                   tx_active_q, tx_active_d, tx_done_q, tx_done_d;

   logic                   push, pop, last_div;
   logic [DATA_WIDTH-1:0]  head;
   logic [DIV_WIDTH-1:0]   teff, div_inc;
   logic [HLF_W-1:0]       half;

   assign wr_if.wr_ready = (count_q < CNT_W'(FIFO_DEPTH));
   assign push     = wr_if.wr_valid && wr_if.wr_ready;
   assign pop      = (state_q == IDLE) && (count_q != '0) && enable_i;
   assign head     = mem[rd_ptr_q];
   // A zero divider behaves as a divide-by-one.
   assign teff     = (target_q == '0) ? DIV_WIDTH'(1) : target_q;
   assign half     = ({1'b0, teff} + HLF_W'(1)) >> 1;
   assign div_inc  = div_cnt_q + DIV_WIDTH'(1);
   assign last_div = (div_cnt_q == teff - DIV_WIDTH'(1));

   // FIFO pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Transmit FSM, divider and registered serial outputs.
   always_comb begin
      state_d     = state_q;
      target_d    = target_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shreg_d     = shreg_q;
      msb_d       = msb_q;
      data_out_d  = data_out_q;
      clk_tx_d    = clk_tx_q;
      tx_active_d = tx_active_q;
      tx_done_d   = 1'b0;

      if (config_div_i && (state_q != SHIFT)) target_d = din_i;

      case (state_q)
         IDLE: begin
            data_out_d  = 1'b0;
            clk_tx_d    = 1'b0;
            tx_active_d = 1'b0;
            if (pop) begin
               state_d     = SHIFT;
               shreg_d     = head;
               msb_d       = msb_first_i;
               div_cnt_d   = '0;
               bit_cnt_d   = '0;
               data_out_d  = msb_first_i ? head[DATA_WIDTH-1] : head[0];
               clk_tx_d    = 1'b1;
               tx_active_d = 1'b1;
            end
         end
         SHIFT: begin
            if (enable_i) begin
               if (last_div) begin
                  div_cnt_d = '0;
                  if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                     state_d     = DONE;
                     data_out_d  = 1'b0;
                     clk_tx_d    = 1'b0;
                     tx_active_d = 1'b0;
                     tx_done_d   = 1'b1;
                  end else begin
                     bit_cnt_d = bit_cnt_q + BIT_W'(1);
                     clk_tx_d  = 1'b1;
                     if (msb_q) begin
                        shreg_d    = shreg_q << 1;
                        data_out_d = shreg_q[DATA_WIDTH-2];
                     end else begin
                        shreg_d    = shreg_q >> 1;
                        data_out_d = shreg_q[1];
                     end
                  end
               end else begin
                  div_cnt_d = div_inc;
                  clk_tx_d  = ({1'b0, div_inc} < half);
               end
            end
         end
         DONE: begin
            state_d     = IDLE;
            data_out_d  = 1'b0;
            clk_tx_d    = 1'b0;
            tx_active_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         target_q    <= DIV_WIDTH'(DIV_DEFAULT);
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         shreg_q     <= '0;
         msb_q       <= 1'b0;
         data_out_q  <= 1'b0;
         clk_tx_q    <= 1'b0;
         tx_active_q <= 1'b0;
         tx_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         target_q    <= target_d;
         div_cnt_q   <= div_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shreg_q     <= shreg_d;
         msb_q       <= msb_d;
         data_out_q  <= data_out_d;
         clk_tx_q    <= clk_tx_d;
         tx_active_q <= tx_active_d;
         tx_done_q   <= tx_done_d;
      end
   end

   // Storage needs no reset; occupancy alone defines valid entries.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= wr_if.wr_data;
   end

   assign data_out_o        = data_out_q;
   assign clk_tx_o          = clk_tx_q;
   assign tx_active_o       = tx_active_q;
   assign tx_done_o         = tx_done_q;
   assign fifo_count_o      = count_q;
   assign freq_div_target_o = target_q;
endmodule

// File: tb/tb_calc_serial_tx_fifo.sv
// Directed bench for calc_serial_tx_fifo with 8-bit words and a 4-deep FIFO.
module tb_calc_serial_tx_fifo;
   localparam int unsigned DW   = 8;
   localparam int unsigned DEP  = 4;
   localparam int unsigned DIVW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            config_div, enable, msb_first;
   logic [DIVW-1:0] din;
   logic            data_out, clk_tx, tx_active, tx_done;
   logic [2:0]      fifo_count;
   logic [DIVW-1:0] target;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   calc_serial_tx_fifo_if #(.DATA_WIDTH(DW)) wr_if ();

   calc_serial_tx_fifo #(
      .DATA_WIDTH(DW), .FIFO_DEPTH(DEP), .DIV_WIDTH(DIVW), .DIV_DEFAULT(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .wr_if(wr_if),
      .config_div_i(config_div), .din_i(din), .enable_i(enable), .msb_first_i(msb_first),
      .data_out_o(data_out), .clk_tx_o(clk_tx), .tx_active_o(tx_active), .tx_done_o(tx_done),
      .fifo_count_o(fifo_count), .freq_div_target_o(target)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [7:0] w);
      wr_if.wr_valid = 1'b1;
      wr_if.wr_data  = w;
      tick();
      wr_if.wr_valid = 1'b0;
   endtask

   task automatic cfg_div(input logic [DIVW-1:0] v);
      config_div = 1'b1;
      din        = v;
      tick();
      config_div = 1'b0;
   endtask

   task automatic wait_active(input string tag);
      int c = 0;
      while (!tx_active && c < 40) begin tick(); c++; end
      chk(tag, tx_active, 1);
   endtask

   task automatic wait_done(input string tag);
      int c = 0;
      while (!tx_done && c < 200) begin tick(); c++; end
      chk(tag, tx_done, 1);
      tick();
   endtask

   // Capture one frame cycle by cycle; optionally pause Enable for pl cycles after sample pa.
   task automatic check_frame(input string tag, input logic [7:0] word, input bit msb,
                              input int teff, input int pa, input int pl);
      logic [63:0] got_d = '0, got_c = '0, exp_d = '0, exp_c = '0;
      int n = 0;
      int e, k;
      wait_active({tag, "_start"});
      while (tx_active && n < 64) begin
         got_d[n] = data_out;
         got_c[n] = clk_tx;
         if (pa >= 0 && n == pa) begin enable = 1'b0; msb_first = ~msb_first; end
         if (pa >= 0 && n == pa + pl) enable = 1'b1;
         n++;
         tick();
      end
      for (int i = 0; i < 8 * teff + pl; i++) begin
         if (pa < 0 || i <= pa) e = i;
         else if (i <= pa + pl) e = pa;
         else e = i - pl;
         k = e / teff;
         exp_d[i] = msb ? word[7 - k] : word[k];
         exp_c[i] = ((e % teff) < ((teff + 1) / 2));
      end
      chk({tag, "_len"}, 64'(n), 64'(8 * teff + pl));
      chk({tag, "_data"}, got_d, exp_d);
      chk({tag, "_clktx"}, got_c, exp_c);
      chk({tag, "_done"}, {data_out, tx_done}, 2'b01);
      tick();
      chk({tag, "_done_clr"}, tx_done, 0);
   endtask

   initial begin
      logic [7:0] wl [5];
      bit seen;
      wl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h99};
      rst_n = 1'b0; config_div = 1'b0; din = '0; enable = 1'b0; msb_first = 1'b0;
      wr_if.wr_valid = 1'b0; wr_if.wr_data = '0;
      repeat (2) tick();
      chk("rst_outs", {data_out, clk_tx, tx_active, tx_done}, 4'b0000);
      chk("rst_count", fifo_count, 0);
      chk("rst_target", target, 2);
      chk("rst_ready", wr_if.wr_ready, 1);
      rst_n = 1'b1;
      tick();

      // Divider load while idle
      cfg_div(3);
      chk("cfg_idle_3", target, 3);
      cfg_div(2);
      chk("cfg_idle_2", target, 2);

      // Single LSB-first frame at T=2
      enable = 1'b1;
      write_word(8'h55);
      chk("w55_count", fifo_count, 1);
      check_frame("lsb55", 8'h55, 1'b0, 2, -1, 0);
      chk("w55_empty", fifo_count, 0);

      // Divider load ignored while shifting
      write_word(8'h0F);
      wait_active("cfg_busy_start");
      cfg_div(5);
      chk("cfg_busy_ignored", target, 2);
      wait_done("cfg_busy_done");

      // Fill while paused, overflow dropped, then drain in order
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         write_word(wl[i]);
         chk($sformatf("fill_count%0d", i), fifo_count, (i < 4) ? i + 1 : 4);
         chk($sformatf("fill_ready%0d", i), wr_if.wr_ready, (i < 3) ? 1 : 0);
      end
      enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         msb_first = i[0];
         check_frame($sformatf("drain%0d", i), wl[i], i[0], 2, -1, 0);
      end
      msb_first = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         if (tx_active) seen = 1'b1;
         tick();
      end
      chk("no_fifth_frame", seen, 0);
      chk("drain_empty", fifo_count, 0);

      // Enable pause mid-frame; MsbFirst flip during pause must not matter
      write_word(8'h3C);
      check_frame("pause", 8'h3C, 1'b0, 2, 5, 6);
      msb_first = 1'b0;

      // Zero divider acts as one, MSB first
      cfg_div(0);
      chk("cfg_zero", target, 0);
      msb_first = 1'b1;
      write_word(8'hA3);
      check_frame("t0_msb", 8'hA3, 1'b1, 1, -1, 0);
      msb_first = 1'b0;

      // Asynchronous reset mid-frame
      cfg_div(5);
      chk("cfg_5", target, 5);
      enable = 1'b0;
      write_word(8'hC1);
      write_word(8'hC2);
      write_word(8'hC3);
      enable = 1'b1;
      wait_active("rst_mid_start");
      repeat (3) tick();
      chk("rst_mid_count_pre", fifo_count, 2);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outs", {data_out, clk_tx, tx_active, tx_done}, 4'b0000);
      chk("rst_mid_count", fifo_count, 0);
      chk("rst_mid_target", target, 2);
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (10) begin
         if (tx_done || tx_active) seen = 1'b1;
         tick();
      end
      chk("rst_mid_no_done", seen, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
